xgmii_rx_frame_chk: RTL and testbench

Receive-side XGMII frame checker for the loopback bench. It consumes the 64-bit XGMII receive word stream, which is looped back from the transmit side at the DUT top. It delineates frames from start to terminate, measures payload length and verifies the incrementing-byte test pattern. Each frame produces one result record plus saturating good/bad counters, which the scoreboard reads.

---
 rtl/xgmii_pkg.sv | 29 ++
 rtl/xgmii_ctrl_lane_dec.sv | 26 ++
 rtl/xgmii_rx_frame_chk.sv | 196 +++++++++++++++++++
 tb/tb_xgmii_rx_frame_chk.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// Shared XGMII control characters, checker state encoding and error-flag layout.
package xgmii_pkg;

    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_ERR   = 8'hFE;
    localparam logic [7:0] XGMII_PRE   = 8'h55;
    localparam logic [7:0] XGMII_SFD   = 8'hD5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } chk_state_e;

    localparam int ERR_PRE  = 0;
    localparam int ERR_LEN  = 1;
    localparam int ERR_PAT  = 2;
    localparam int ERR_CTRL = 3;
    localparam int ERR_PORT = 4;
    localparam int ERR_W    = 5;

    // Full start word: control only on lane 0, then six preamble bytes and the SFD.
    function automatic logic preamble_ok(input logic [63:0] d, input logic [7:0] c);
        return (c == 8'h01) && (d[7:0] == XGMII_START) &&
               (d[55:8] == {6{XGMII_PRE}}) && (d[63:56] == XGMII_SFD);
    endfunction

endpackage

// File: rtl/xgmii_ctrl_lane_dec.sv
// Priority encoder locating the lowest XGMII control lane (8 when none) and its byte.
module xgmii_ctrl_lane_dec
    import xgmii_pkg::*;
(
    input  logic [63:0] rxd_i,
    input  logic [7:0]  rxc_i,
    output logic        ctrl_found_o,
    output logic [3:0]  ctrl_lane_o,
    output logic [7:0]  ctrl_byte_o
);

    always_comb begin
        ctrl_found_o = 1'b0;
        ctrl_lane_o  = 4'd8;
        ctrl_byte_o  = XGMII_IDLE;
        // Scan from the top so the lowest set lane is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (rxc_i[i]) begin
                ctrl_found_o = 1'b1;
                ctrl_lane_o  = 4'(i);
                ctrl_byte_o  = rxd_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/xgmii_rx_frame_chk.sv
// XGMII receive frame checker: delineates frames, measures length, verifies the
// incrementing-byte pattern and reports one result record per frame.
module xgmii_rx_frame_chk
    import xgmii_pkg::*;
#(
    parameter int PORT_W  = 4,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32
) (
    input  logic              I_156m25_clk,
    input  logic              I_rst_n,
    input  logic [63:0]       I_xgmii_rxd,
    input  logic [7:0]        I_xgmii_rxc,
    input  logic [PORT_W-1:0] I_xgmii_rxport_num,
    input  logic              I_cnt_clr,
    output logic              O_frm_vld,
    output logic [15:0]       O_frm_len,
    output logic [PORT_W-1:0] O_frm_port,
    output logic [4:0]        O_frm_err,
    output logic [CNT_W-1:0]  O_good_cnt,
    output logic [CNT_W-1:0]  O_bad_cnt
);

    chk_state_e        state_q, state_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        exp_q, exp_d;
    logic              seed_vld_q, seed_vld_d;
    logic [ERR_W-1:0]  flags_q, flags_d;

    logic              frm_vld_q, frm_vld_d;
    logic [15:0]       frm_len_q, frm_len_d;
    logic [PORT_W-1:0] frm_port_q, frm_port_d;
    logic [ERR_W-1:0]  frm_err_q, frm_err_d;
    logic [CNT_W-1:0]  good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]  bad_cnt_q, bad_cnt_d;

    logic              ctrl_found;
    logic [3:0]        ctrl_lane;
    logic [7:0]        ctrl_byte;

    xgmii_ctrl_lane_dec u_lane_dec (
        .rxd_i        (I_xgmii_rxd),
        .rxc_i        (I_xgmii_rxc),
        .ctrl_found_o (ctrl_found),
        .ctrl_lane_o  (ctrl_lane),
        .ctrl_byte_o  (ctrl_byte)
    );

    logic             is_start;
    logic             is_term;
    logic [ERR_W-1:0] start_flags;
    logic [ERR_W-1:0] word_flags;
    logic [7:0]       pat_base;
    logic [7:0]       lane_mis;
    logic [16:0]      cnt_sum;
    logic [15:0]      cnt_sat;
    logic             len_bad;

    // A start in lane 0 always decodes as control lane 0, so it doubles as the restart test.
    assign is_start = I_xgmii_rxc[0] && (I_xgmii_rxd[7:0] == XGMII_START);
    assign is_term  = ctrl_found && (ctrl_byte == XGMII_TERM);

    always_comb begin
        start_flags          = '0;
        start_flags[ERR_PRE] = !preamble_ok(I_xgmii_rxd, I_xgmii_rxc);
    end

    // Until the seed is known, lane 0 of this word is the seed itself.
    assign pat_base = seed_vld_q ? exp_q : I_xgmii_rxd[7:0];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pat
            assign lane_mis[gi] = (4'(gi) < ctrl_lane) &&
                                  (I_xgmii_rxd[8*gi +: 8] != pat_base + 8'(gi));
        end
    endgenerate

    assign cnt_sum = {1'b0, cnt_q} + {13'd0, ctrl_lane};
    assign cnt_sat = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    assign len_bad = (cnt_sat < 16'(MIN_LEN)) || (cnt_sat > 16'(MAX_LEN));

    always_comb begin
        word_flags           = flags_q;
        word_flags[ERR_PAT]  = flags_q[ERR_PAT] | (|lane_mis);
        word_flags[ERR_PORT] = flags_q[ERR_PORT] | (I_xgmii_rxport_num != port_q);
    end

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        seed_vld_d = seed_vld_q;
        flags_d    = flags_q;
        frm_vld_d  = 1'b0;
        frm_len_d  = frm_len_q;
        frm_port_d = frm_port_q;
        frm_err_d  = frm_err_q;
        case (state_q)
            ST_IDLE: begin
                if (is_start) begin
                    state_d    = ST_DATA;
                    port_d     = I_xgmii_rxport_num;
                    cnt_d      = '0;
                    exp_d      = '0;
                    seed_vld_d = 1'b0;
                    flags_d    = start_flags;
                end
            end
            ST_DATA: begin
                if (is_term) begin
                    frm_vld_d          = 1'b1;
                    frm_len_d          = cnt_sat;
                    frm_port_d         = port_q;
                    frm_err_d          = word_flags;
                    frm_err_d[ERR_LEN] = len_bad;
                    state_d            = ST_IDLE;
                end else if (is_start) begin
                    // Restart word carries no payload; it closes the old frame and opens a new one.
                    frm_vld_d           = 1'b1;
                    frm_len_d           = cnt_q;
                    frm_port_d          = port_q;
                    frm_err_d           = flags_q;
                    frm_err_d[ERR_CTRL] = 1'b1;
                    port_d              = I_xgmii_rxport_num;
                    cnt_d               = '0;
                    exp_d               = '0;
                    seed_vld_d          = 1'b0;
                    flags_d             = start_flags;
                end else begin
                    cnt_d             = cnt_sat;
                    exp_d             = pat_base + 8'(ctrl_lane);
                    seed_vld_d        = seed_vld_q | (ctrl_lane != 4'd0);
                    flags_d           = word_flags;
                    flags_d[ERR_CTRL] = word_flags[ERR_CTRL] | ctrl_found;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (I_cnt_clr) begin
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (frm_vld_d) begin
            if (frm_err_d == '0) begin
                good_cnt_d = (&good_cnt_q) ? good_cnt_q : good_cnt_q + 1'b1;
            end else begin
                bad_cnt_d = (&bad_cnt_q) ? bad_cnt_q : bad_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge I_156m25_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= ST_IDLE;
            port_q     <= '0;
            cnt_q      <= '0;
            exp_q      <= '0;
            seed_vld_q <= 1'b0;
            flags_q    <= '0;
            frm_vld_q  <= 1'b0;
            frm_len_q  <= '0;
            frm_port_q <= '0;
            frm_err_q  <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            seed_vld_q <= seed_vld_d;
            flags_q    <= flags_d;
            frm_vld_q  <= frm_vld_d;
            frm_len_q  <= frm_len_d;
            frm_port_q <= frm_port_d;
            frm_err_q  <= frm_err_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign O_frm_vld  = frm_vld_q;
    assign O_frm_len  = frm_len_q;
    assign O_frm_port = frm_port_q;
    assign O_frm_err  = frm_err_q;
    assign O_good_cnt = good_cnt_q;
    assign O_bad_cnt  = bad_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_frame_chk.sv
// Bench for xgmii_rx_frame_chk: directed frame table, hand-built corner sequences and
// randomized frames scored against a frame-level reference model.
`timescale 1ns/1ps
module tb_xgmii_rx_frame_chk;

    localparam logic [63:0] IDLE_W = {8{8'h07}};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic [3:0]  port;
    logic        cnt_clr;
    logic        frm_vld;
    logic [15:0] frm_len;
    logic [3:0]  frm_port;
    logic [4:0]  frm_err;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;

    always #5 clk = ~clk;

    xgmii_rx_frame_chk #(
        .PORT_W(4), .MIN_LEN(64), .MAX_LEN(1518), .CNT_W(32)
    ) dut (
        .I_156m25_clk       (clk),
        .I_rst_n            (rst_n),
        .I_xgmii_rxd        (rxd),
        .I_xgmii_rxc        (rxc),
        .I_xgmii_rxport_num (port),
        .I_cnt_clr          (cnt_clr),
        .O_frm_vld          (frm_vld),
        .O_frm_len          (frm_len),
        .O_frm_port         (frm_port),
        .O_frm_err          (frm_err),
        .O_good_cnt         (good_cnt),
        .O_bad_cnt          (bad_cnt)
    );

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [15:0] len;
        logic [3:0]  port;
        logic [4:0]  err;
    } exp_t;
    typedef struct {
        int          len;
        logic [7:0]  seed;
        int          cidx;
        logic [7:0]  cval;
        logic [3:0]  p0;
        int          chg;
        logic [3:0]  p1;
        bit          pre_bad;
        logic [15:0] e_len;
        logic [3:0]  e_port;
        logic [4:0]  e_err;
    } vec_t;

    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model_good = 0;
    logic [31:0] model_bad  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vld"},  64'(frm_vld),  0);
        check({tag, "_len"},  64'(frm_len),  0);
        check({tag, "_port"}, 64'(frm_port), 0);
        check({tag, "_err"},  64'(frm_err),  0);
        check({tag, "_good"}, 64'(good_cnt), 0);
        check({tag, "_bad"},  64'(bad_cnt),  0);
    endtask

    // Apply one word for one clock, then score any report and the counters.
    task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic [3:0] p);
        logic clr;
        exp_t e;
        rxd  = d;
        rxc  = c;
        port = p;
        clr  = cnt_clr;
        @(posedge clk);
        #1;
        if (frm_vld) begin
            $display("report len=%0d port=%0d err=%05b good=%0d bad=%0d",
                     frm_len, frm_port, frm_err, good_cnt, bad_cnt);
            if (exp_q.size() == 0) begin
                check("unexpected_vld", 64'(frm_vld), 0);
            end else begin
                e = exp_q.pop_front();
                check("frm_len",  64'(frm_len),  64'(e.len));
                check("frm_port", 64'(frm_port), 64'(e.port));
                check("frm_err",  64'(frm_err),  64'(e.err));
                if (!clr) begin
                    if (e.err == 5'd0) model_good++;
                    else               model_bad++;
                end
            end
        end
        if (clr) begin
            model_good = 0;
            model_bad  = 0;
        end
        if (frm_vld || clr) begin
            check("good_cnt", 64'(good_cnt), 64'(model_good));
            check("bad_cnt",  64'(bad_cnt),  64'(model_bad));
        end
    endtask

    function automatic logic [63:0] start_word(input bit bad);
        logic [63:0] w = {8'hD5, {6{8'h55}}, 8'hFB};
        if (bad) w[31:24] = 8'h54;
        return w;
    endfunction

    function automatic logic [63:0] inc_word(input logic [7:0] base);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = base + 8'(k);
        return w;
    endfunction

    function automatic byte_q_t make_payload(input int len, input logic [7:0] seed,
                                             input int cidx, input logic [7:0] cval);
        byte_q_t q;
        for (int n = 0; n < len; n++) q.push_back(seed + 8'(n));
        if (cidx >= 0 && cidx < len) q[cidx] = cval;
        return q;
    endfunction

    // Reference model: judges a frame from its payload bytes and how it was sent.
    function automatic exp_t model_exp(input byte_q_t pl, input logic [3:0] p0, input int chg,
                                       input logic [3:0] p1, input bit pre_bad);
        exp_t e;
        bit   pat;
        int   n;
        pat = 1'b0;
        n   = pl.size();
        for (int i = 1; i < n; i++) if (pl[i] != pl[0] + 8'(i)) pat = 1'b1;
        e.len  = (n > 65535) ? 16'hFFFF : 16'(n);
        e.port = p0;
        e.err  = {(chg >= 0 && chg <= n / 8 && p1 != p0), 1'b0, pat,
                  (n < 64 || n > 1518), pre_bad};
        return e;
    endfunction

    // Payload words (port switches to p1 from data word chg on), then optionally the terminate word.
    task automatic send_body(input byte_q_t pl, input logic [3:0] p0, input int chg,
                             input logic [3:0] p1, input bit term, input bit clr_term);
        int          nfull;
        int          rem;
        logic [63:0] d;
        logic [7:0]  c;
        nfull = pl.size() / 8;
        rem   = pl.size() % 8;
        for (int w = 0; w < nfull; w++) begin
            for (int k = 0; k < 8; k++) d[8*k +: 8] = pl[8*w + k];
            drive(d, 8'h00, (chg >= 0 && w >= chg) ? p1 : p0);
        end
        if (term) begin
            d = IDLE_W;
            c = 8'hFF;
            for (int k = 0; k < rem; k++) begin
                d[8*k +: 8] = pl[8*nfull + k];
                c[k]        = 1'b0;
            end
            d[8*rem +: 8] = 8'hFD;
            cnt_clr = clr_term;
            drive(d, c, (chg >= 0 && nfull >= chg) ? p1 : p0);
            cnt_clr = 1'b0;
            check("vld_after_term", 64'(frm_vld), 1);
        end
    endtask

    task automatic send_frame(input byte_q_t pl, input logic [3:0] p0, input int chg,
                              input logic [3:0] p1, input bit pre_bad, input bit clr_term);
        drive(start_word(pre_bad), 8'h01, p0);
        send_body(pl, p0, chg, p1, 1'b1, clr_term);
    endtask

    task automatic run_random(input int nframes);
        byte_q_t    pl;
        int         len;
        int         cidx;
        int         chg;
        logic [7:0] seed;
        logic [3:0] p0;
        logic [3:0] p1;
        bit         pre_bad;
        int         gap;
        for (int f = 0; f < nframes; f++) begin
            len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1400, 1600))
                                               : int'($urandom_range(0, 200));
            seed = 8'($urandom);
            cidx = -1;
            if (len > 0 && $urandom_range(0, 3) == 0) cidx = $urandom_range(0, len - 1);
            pl = make_payload(len, seed, -1, 8'h00);
            if (cidx >= 0) pl[cidx] = pl[cidx] ^ 8'($urandom_range(1, 255));
            p0      = 4'($urandom);
            p1      = 4'($urandom);
            chg     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len / 8)) : -1;
            pre_bad = ($urandom_range(0, 7) == 0);
            exp_q.push_back(model_exp(pl, p0, chg, p1, pre_bad));
            send_frame(pl, p0, chg, p1, pre_bad, 1'b0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) drive(IDLE_W, 8'hFF, 4'($urandom));
        end
    endtask

    vec_t    tbl [11];
    byte_q_t pl;
    logic [63:0] wd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{64,    8'h00, -1, 8'h00, 4'd0, -1, 4'd0, 1'b0, 16'd64,    4'd0, 5'b00000};
        tbl[1]  = '{64,    8'h00, 16, 8'hAA, 4'd0, -1, 4'd0, 1'b0, 16'd64,    4'd0, 5'b00100};
        tbl[2]  = '{60,    8'h00, -1, 8'h00, 4'd0, -1, 4'd0, 1'b0, 16'd60,    4'd0, 5'b00010};
        tbl[3]  = '{64,    8'h00, -1, 8'h00, 4'd3,  4, 4'd5, 1'b0, 16'd64,    4'd3, 5'b10000};
        tbl[4]  = '{1518,  8'h80, -1, 8'h00, 4'd7, -1, 4'd7, 1'b0, 16'd1518,  4'd7, 5'b00000};
        tbl[5]  = '{1519,  8'h00, -1, 8'h00, 4'd1, -1, 4'd1, 1'b0, 16'd1519,  4'd1, 5'b00010};
        tbl[6]  = '{63,    8'h00, -1, 8'h00, 4'd0, -1, 4'd0, 1'b0, 16'd63,    4'd0, 5'b00010};
        tbl[7]  = '{64,    8'h00, -1, 8'h00, 4'd2, -1, 4'd2, 1'b1, 16'd64,    4'd2, 5'b00001};
        tbl[8]  = '{65,    8'hF0, -1, 8'h00, 4'd9, -1, 4'd9, 1'b0, 16'd65,    4'd9, 5'b00000};
        tbl[9]  = '{70000, 8'h12, -1, 8'h00, 4'd4, -1, 4'd4, 1'b0, 16'hFFFF,  4'd4, 5'b00010};
        tbl[10] = '{64,    8'h05,  0, 8'h99, 4'd8, -1, 4'd8, 1'b0, 16'd64,    4'd8, 5'b00100};

        rst_n   = 1'b0;
        rxd     = IDLE_W;
        rxc     = 8'hFF;
        port    = 4'd0;
        cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("in_reset");
        @(negedge clk) rst_n = 1'b1;
        drive(IDLE_W, 8'hFF, 4'd0);
        check_zero("after_reset");

        for (int i = 0; i < 11; i++) begin
            pl = make_payload(tbl[i].len, tbl[i].seed, tbl[i].cidx, tbl[i].cval);
            exp_q.push_back('{tbl[i].e_len, tbl[i].e_port, tbl[i].e_err});
            send_frame(pl, tbl[i].p0, tbl[i].chg, tbl[i].p1, tbl[i].pre_bad, 1'b0);
            drive(IDLE_W, 8'hFF, 4'd0);
        end

        // Restart after 24 payload bytes, then a clean 64-byte frame with no new start word.
        drive(start_word(1'b0), 8'h01, 4'd6);
        for (int w = 0; w < 3; w++) drive(inc_word(8'(8 * w)), 8'h00, 4'd6);
        exp_q.push_back('{16'd24, 4'd6, 5'b01000});
        drive(start_word(1'b0), 8'h01, 4'd6);
        check("vld_after_restart", 64'(frm_vld), 1);
        exp_q.push_back('{16'd64, 4'd6, 5'b00000});
        send_body(make_payload(64, 8'h40, -1, 8'h00), 4'd6, -1, 4'd6, 1'b1, 1'b0);
        drive(IDLE_W, 8'hFF, 4'd0);

        // FE in lane 3 mid-frame: three bytes count, the rest of that word is ignored.
        exp_q.push_back('{16'd67, 4'd2, 5'b01000});
        drive(start_word(1'b0), 8'h01, 4'd2);
        drive(inc_word(8'h00), 8'h00, 4'd2);
        wd = inc_word(8'h08);
        wd[31:24] = 8'hFE;
        drive(wd, 8'h08, 4'd2);
        send_body(make_payload(56, 8'h0B, -1, 8'h00), 4'd2, -1, 4'd2, 1'b1, 1'b0);
        drive(IDLE_W, 8'hFF, 4'd0);

        run_random(60);
        drive(IDLE_W, 8'hFF, 4'd0);

        cnt_clr = 1'b1;
        drive(IDLE_W, 8'hFF, 4'd0);
        cnt_clr = 1'b0;
        check("clr_idle_good", 64'(good_cnt), 0);
        check("clr_idle_bad",  64'(bad_cnt),  0);

        // Build up a counted frame, then reset in the middle of the next one.
        exp_q.push_back('{16'd64, 4'd0, 5'b00000});
        send_frame(make_payload(64, 8'h00, -1, 8'h00), 4'd0, -1, 4'd0, 1'b0, 1'b0);
        drive(start_word(1'b0), 8'h01, 4'd1);
        drive(inc_word(8'h00), 8'h00, 4'd1);
        drive(inc_word(8'h08), 8'h00, 4'd1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        exp_q.delete();
        model_good = 0;
        model_bad  = 0;
        drive(inc_word(8'h10), 8'h00, 4'd1);
        drive(IDLE_W, 8'hFF, 4'd1);
        @(negedge clk) rst_n = 1'b1;
        exp_q.push_back('{16'd64, 4'd1, 5'b00000});
        send_frame(make_payload(64, 8'h00, -1, 8'h00), 4'd1, -1, 4'd1, 1'b0, 1'b0);
        check("good_after_reset", 64'(good_cnt), 1);
        drive(IDLE_W, 8'hFF, 4'd0);

        // Clear coincident with a report: clear wins, the frame is not counted.
        exp_q.push_back('{16'd64, 4'd0, 5'b00000});
        send_frame(make_payload(64, 8'h00, -1, 8'h00), 4'd0, -1, 4'd0, 1'b0, 1'b1);
        check("clr_report_good", 64'(good_cnt), 0);
        check("clr_report_bad",  64'(bad_cnt),  0);
        drive(IDLE_W, 8'hFF, 4'd0);

        check("reports_outstanding", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
